// File: rtl/encoder_8to3_hs_if.sv
// Request/code bundle between request sources, the 8-to-3 encoder and its consumer.
// The master side drives requests and ready; the slave side (encoder) drives the code.
interface encoder_8to3_hs_if;
    logic d0, d1, d2, d3, d4, d5, d6, d7;
    logic ready;
    logic a, b, c;
    logic valid;
    logic idle;

    modport master (
        output d0, d1, d2, d3, d4, d5, d6, d7, ready,
        input  a, b, c, valid, idle
    );

    modport slave (
        input  d0, d1, d2, d3, d4, d5, d6, d7, ready,
        output a, b, c, valid, idle
    );
endinterface

// File: rtl/encoder_8to3_hs.sv
// Registered 8-to-3 priority encoder with sticky pending requests and a valid/ready
// output; each accepted code clears its own pending bit.
module encoder_8to3_hs #(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    encoder_8to3_hs_if.slave         bus
);
    localparam int unsigned N_REQ  = 8;
    localparam int unsigned CODE_W = 3;

    logic [N_REQ-1:0]  pend;
    logic [N_REQ-1:0]  dv;
    logic [N_REQ-1:0]  clr;
    logic [N_REQ-1:0]  src;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] sel;
    logic              valid_q;
    logic              acc;
    logic              ld;

    assign dv  = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
    assign acc = valid_q & bus.ready;
    assign ld  = ~valid_q | acc;
    assign clr = acc ? (N_REQ'(1) << code) : '0;
    // Selection sees only registered pend, minus the bit being accepted this cycle.
    assign src = pend & ~clr;

    // Priority pick over src; the last match in scan order wins.
    always_comb begin
        sel = '0;
        if (HI_FIRST) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (src[i]) sel = CODE_W'(i);
            end
        end else begin
            for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
                if (src[i]) sel = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            code    <= '0;
            valid_q <= 1'b0;
        end else begin
            // New requests win over a same-cycle clear so a held line re-requests.
            pend <= src | dv;
            if (ld) begin
                if (src != '0) begin
                    code    <= sel;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.a     = code[2];
    assign bus.b     = code[1];
    assign bus.c     = code[0];
    assign bus.valid = valid_q;
    assign bus.idle  = (pend == '0) & ~valid_q;
endmodule

// File: tb/tb_encoder_8to3_hs.sv
// Scoreboard bench: two encoders (HI_FIRST=1 and HI_FIRST=0) share stimulus; expected
// codes are queued per instance and popped by a monitor on every accepted output.
module tb_encoder_8to3_hs;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_hi[$];
    int   exp_lo[$];

    encoder_8to3_hs_if hi_if ();
    encoder_8to3_hs_if lo_if ();

    encoder_8to3_hs #(.HI_FIRST(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(hi_if));
    encoder_8to3_hs #(.HI_FIRST(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(lo_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [7:0] v, input logic r);
        {hi_if.d7, hi_if.d6, hi_if.d5, hi_if.d4, hi_if.d3, hi_if.d2, hi_if.d1, hi_if.d0} = v;
        {lo_if.d7, lo_if.d6, lo_if.d5, lo_if.d4, lo_if.d3, lo_if.d2, lo_if.d1, lo_if.d0} = v;
        hi_if.ready = r;
        lo_if.ready = r;
    endtask

    // Advance to just after the next rising edge; inputs set now are seen at the following edge.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    function automatic int code_hi();
        return int'({hi_if.a, hi_if.b, hi_if.c});
    endfunction

    function automatic int code_lo();
        return int'({lo_if.a, lo_if.b, lo_if.c});
    endfunction

    // Monitor: every accepted code must match the head of that instance's queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (hi_if.valid && hi_if.ready) begin
                if (exp_hi.size() == 0) chk("hi_unexpected_code", code_hi(), -1);
                else chk("hi_accept_code", code_hi(), exp_hi.pop_front());
            end
            if (lo_if.valid && lo_if.ready) begin
                if (exp_lo.size() == 0) chk("lo_unexpected_code", code_lo(), -1);
                else chk("lo_accept_code", code_lo(), exp_lo.pop_front());
            end
        end
    end

    task automatic run_pair_test(input string tag);
        exp_hi.push_back(6); exp_hi.push_back(2);
        exp_lo.push_back(2); exp_lo.push_back(6);
        set_in(8'h44, 1'b1);
        nxt();
        set_in(8'h00, 1'b1);
        nxt();
        chk({tag, "_hi_first"}, code_hi(), 6);
        chk({tag, "_lo_first"}, code_lo(), 2);
        nxt();
        chk({tag, "_hi_second"}, code_hi(), 2);
        chk({tag, "_lo_second"}, code_lo(), 6);
        chk({tag, "_hi_second_valid"}, int'(hi_if.valid), 1);
        nxt();
        chk({tag, "_hi_drained"}, int'(hi_if.valid), 0);
        chk({tag, "_lo_drained"}, int'(lo_if.valid), 0);
        chk({tag, "_hi_idle"}, int'(hi_if.idle), 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_in(8'h00, 1'b0);

        // Reset state
        nxt();
        nxt();
        chk("rst_valid", int'(hi_if.valid), 0);
        chk("rst_code", code_hi(), 0);
        chk("rst_idle", int'(hi_if.idle), 1);
        chk("rst_lo_idle", int'(lo_if.idle), 1);
        rst = 1'b0;

        // Single pulse on d5
        exp_hi.push_back(5);
        exp_lo.push_back(5);
        set_in(8'h20, 1'b1);
        nxt();
        chk("d5_not_yet", int'(hi_if.valid), 0);
        set_in(8'h00, 1'b1);
        nxt();
        chk("d5_valid", int'(hi_if.valid), 1);
        chk("d5_code", code_hi(), 5);
        nxt();
        chk("d5_after_valid", int'(hi_if.valid), 0);
        chk("d5_after_idle", int'(hi_if.idle), 1);

        // d2 and d6 together
        run_pair_test("pair");

        // Backpressure: d3 held at output while d7 arrives
        exp_hi.push_back(3); exp_hi.push_back(7);
        exp_lo.push_back(3); exp_lo.push_back(7);
        set_in(8'h08, 1'b0);
        nxt();
        set_in(8'h00, 1'b0);
        nxt();
        for (int k = 0; k < 5; k++) begin
            set_in((k == 0) ? 8'h80 : 8'h00, 1'b0);
            chk("stall_valid", int'(hi_if.valid), 1);
            chk("stall_code", code_hi(), 3);
            nxt();
        end
        chk("stall_not_idle", int'(hi_if.idle), 0);
        set_in(8'h00, 1'b1);
        nxt();
        chk("stall_next_code", code_hi(), 7);
        chk("stall_next_valid", int'(hi_if.valid), 1);
        nxt();
        chk("stall_drained", int'(hi_if.valid), 0);
        chk("stall_idle", int'(hi_if.idle), 1);

        // Held d4: one code every other cycle, one more after release
        for (int k = 0; k < 3; k++) begin
            exp_hi.push_back(4);
            exp_lo.push_back(4);
        end
        set_in(8'h10, 1'b1);
        nxt();
        nxt();
        chk("hold_v0", int'(hi_if.valid), 1);
        chk("hold_code", code_hi(), 4);
        nxt();
        chk("hold_v1", int'(hi_if.valid), 0);
        nxt();
        chk("hold_v2", int'(hi_if.valid), 1);
        nxt();
        chk("hold_v3", int'(hi_if.valid), 0);
        set_in(8'h00, 1'b1);
        nxt();
        chk("release_last_valid", int'(hi_if.valid), 1);
        chk("release_last_code", code_hi(), 4);
        nxt();
        chk("release_drained", int'(hi_if.valid), 0);
        chk("release_idle", int'(hi_if.idle), 1);

        // Reset with everything pending and a code on the output
        set_in(8'hFF, 1'b0);
        nxt();
        nxt();
        chk("full_hi_code", code_hi(), 7);
        chk("full_lo_code", code_lo(), 0);
        chk("full_valid", int'(hi_if.valid), 1);
        rst = 1'b1;
        set_in(8'h00, 1'b0);
        nxt();
        chk("midrst_valid", int'(hi_if.valid), 0);
        chk("midrst_code", code_hi(), 0);
        chk("midrst_idle", int'(hi_if.idle), 1);
        rst = 1'b0;
        nxt();
        chk("postrst_idle", int'(hi_if.idle), 1);
        chk("postrst_lo_idle", int'(lo_if.idle), 1);

        run_pair_test("pair2");

        nxt();
        nxt();
        chk("hi_queue_empty", exp_hi.size(), 0);
        chk("lo_queue_empty", exp_lo.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
